apb_slave_mem: RTL
==================

// Module: apb_slave_mem
// PURPOSE
//  - Parametrised APB3/APB4 completer with a flop-based word memory.
//  - Adds over the previous generation: programmable wait states, byte write strobes,
//    read-only low region, PSLVERR on bad access, and protocol-violation detection.
//  - Sits behind the APB bridge as a scratch/config register bank for SoC peripherals.
// PARAMETERS
//  ADDR_W      8   word address width of p_addr
//  DATA_W      32  data width; must be a multiple of 8
//  DEPTH       16  number of words implemented; word index = p_addr; DEPTH <= 2**ADDR_W
//  WAIT_STATES 0   extra ACCESS cycles before p_ready (0..15)
//  RO_WORDS    0   words [0, RO_WORDS) are read-only; writes to them error
// PORTS
//  p_clk       in   1         clock
//  p_reset     in   1         reset, asynchronous, active-high
//  p_sel       in   1         completer select
//  p_enable    in   1         access phase
//  p_write     in   1         1 = write, 0 = read
//  p_addr      in   ADDR_W    word address
//  p_wdata     in   DATA_W    write data
//  p_strb      in   DATA_W/8  byte write strobes; ignored on reads
//  p_ready     out  1         transfer completes this cycle
//  p_rdata     out  DATA_W    read data; valid only when p_ready & !p_write
//  p_slverr    out  1         error response; valid only when p_ready
//  p_proterr   out  1         one-cycle pulse on an APB protocol violation
// BEHAVIOUR
//  - Reset value of p_reset is asynchronous, active-high; clock is p_clk.
//  - On reset: state=IDLE, wait counter=0, p_ready=0, p_rdata=0, p_slverr=0,
//    p_proterr=0, all memory words=0.
//  - A reset mid-transfer aborts the transfer with no memory write.
//  - FSM states: IDLE, ACCESS.
//    - IDLE -> ACCESS on an edge with p_sel & !p_enable (setup phase).
//      - Captures addr_q, write_q, wdata_q, strb_q.
//      - Loads wcnt = WAIT_STATES.
//    - In ACCESS with p_sel & p_enable:
//      - if wcnt != 0, decrement wcnt; p_ready stays 0.
//      - if wcnt == 0, p_ready=1 for exactly this cycle; next state = IDLE.
//    - Latency: p_ready rises in the (WAIT_STATES+1)th ACCESS cycle.
//      - With WAIT_STATES=0, that is the first p_enable cycle.
//  - p_ready, p_slverr and p_rdata are decoded from registered state only;
//    there are no combinational paths from inputs to outputs.
//  - Error: err = (addr_q >= DEPTH) | (write_q & addr_q < RO_WORDS).
//    - p_slverr = p_ready & err.
//  - Write: on the edge closing the p_ready cycle, if !err, each byte i with strb_q[i]=1
//    is updated from wdata_q. Strobe 0 leaves that byte unchanged.
//    - An error write modifies nothing.
//  - Read: p_rdata = mem[addr_q] while p_ready & !write_q & !err; otherwise p_rdata = 0.
//  - Back-to-back transfers: after completion the FSM is in IDLE.
//    - The master's next setup cycle is accepted immediately.
//    - Throughput is therefore 1 transfer per (2 + WAIT_STATES) cycles.
//  - Protocol violations cause p_proterr=1 for one cycle; no memory write, no p_ready:
//    - in IDLE, p_sel & p_enable with no setup: stay IDLE.
//    - in ACCESS, p_sel=0 or p_enable=0 before completion: abort to IDLE.
//    - in ACCESS, p_addr, p_write or p_wdata change vs captured value: abort to IDLE.
//  - Read of a just-written address in the next transfer returns the new data;
//    the memory is updated before the next setup edge.
// STRUCTURE
//  - Package apb_pkg:
//    - state enum {IDLE, ACCESS};
//    - localparam STRB_W = DATA_W/8;
//    - localparam WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES+1) : 1.
//  - Sub-module apb_mem_bank (DEPTH x DATA_W flops, byte-enable write port,
//    async read, reset clear).
//  - The top level holds the FSM, wait counter, capture registers and error decode.
// TESTING
//  1. Reset, then read addr 3 -> p_ready in 1st ACCESS cycle, p_rdata=0, p_slverr=0.
//  2. Write 0xDEADBEEF to 5 with strb=4'hF, then read 5 -> 0xDEADBEEF.
//     Then write 0x00001122 to 5 with strb=4'b0011, then read 5 -> 0xDEAD1122.
//  3. WAIT_STATES=3: write then read addr 2 -> p_ready low for 3 ACCESS cycles,
//     high on the 4th; each transfer takes 5 cycles.
//  4. DEPTH=16, RO_WORDS=2:
//     - write addr 20 -> p_slverr=1, no change;
//     - write 0x55 to addr 1 -> p_slverr=1, mem[1] stays 0;
//     - read addr 20 -> p_slverr=1, p_rdata=0.
//  5. Drop p_sel in the 2nd ACCESS cycle with WAIT_STATES=2 ->
//     p_proterr pulse, no write, FSM back in IDLE.
//     Assert p_sel & p_enable with no setup -> p_proterr pulse, p_ready stays 0.
//  6. Assert p_reset mid-ACCESS of a write to 7 -> outputs 0 immediately;
//     a later read of 7 returns 0. Back-to-back write/read of 9 with no idle gap
//     -> read returns the written data.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the APB scratch/config memory.
// Widths that depend on module parameters are derived via the functions below.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

  // Wait counter must hold WAIT_STATES; keep at least one bit when there are none.
  function automatic int wcnt_width(input int wait_states);
    return (wait_states > 0) ? $clog2(wait_states + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB completer bus bundle: request signals from the bridge, response signals back.
interface apb_slave_mem_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  localparam int STRB_W = strb_width(DATA_W);

  logic              p_sel;
  logic              p_enable;
  logic              p_write;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [STRB_W-1:0] p_strb;
  logic              p_ready;
  logic [DATA_W-1:0] p_rdata;
  logic              p_slverr;
  logic              p_proterr;

  modport slave (
    input  p_sel, p_enable, p_write, p_addr, p_wdata, p_strb,
    output p_ready, p_rdata, p_slverr, p_proterr
  );

  modport master (
    output p_sel, p_enable, p_write, p_addr, p_wdata, p_strb,
    input  p_ready, p_rdata, p_slverr, p_proterr
  );
endinterface

// File: rtl/apb_mem_bank.sv
// DEPTH x DATA_W flop memory with a byte-enable write port and asynchronous read.
// The whole array clears on reset so config words start from a known value.
module apb_mem_bank
  import apb_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int STRB_W = strb_width(DATA_W)
) (
  input  logic              p_clk,
  input  logic              p_reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] strb,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [STRB_W-1:0] lane_we;

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      assign lane_we[gi] = we & strb[gi];
    end
  endgenerate

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_reg[w] <= '0;
      end
    end else begin
      for (int b = 0; b < STRB_W; b++) begin
        if (lane_we[b]) begin
          mem_reg[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_reg[addr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3/APB4 completer fronting a small word memory: wait states, byte strobes,
// read-only low region, PSLVERR on bad access and protocol-violation pulses.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter int RO_WORDS    = 0
) (
  input  logic            p_clk,
  input  logic            p_reset,
  apb_slave_mem_if.slave  bus
);

  localparam int STRB_W = strb_width(DATA_W);
  localparam int WCNT_W = wcnt_width(WAIT_STATES);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WAIT_STATES);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  apb_state_e        state_reg;
  logic [WCNT_W-1:0] wcnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              write_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [STRB_W-1:0] strb_reg;
  logic              proterr_reg;

  logic              ready;
  logic              out_of_range;
  logic              in_ro;
  logic              err;
  logic              access_ok;
  logic              mem_we;
  logic [DATA_W-1:0] rd_word;

  assign out_of_range = ({1'b0, addr_reg} >= DEPTH_L);

  generate
    if (RO_WORDS > 0) begin : g_ro
      localparam logic [ADDR_W:0] RO_L = (ADDR_W + 1)'(RO_WORDS);
      assign in_ro = ({1'b0, addr_reg} < RO_L);
    end else begin : g_no_ro
      assign in_ro = 1'b0;
    end
  endgenerate

  assign err = out_of_range | (write_reg & in_ro);

  // The master must hold select, enable and the captured request steady until completion.
  assign access_ok = bus.p_sel & bus.p_enable
                   & (bus.p_addr  == addr_reg)
                   & (bus.p_write == write_reg)
                   & (bus.p_wdata == wdata_reg);

  assign ready  = (state_reg == ACCESS) && (wcnt_reg == '0);
  assign mem_we = ready & access_ok & write_reg & ~err;

  apb_mem_bank #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .STRB_W (STRB_W)
  ) u_bank (
    .p_clk   (p_clk),
    .p_reset (p_reset),
    .we      (mem_we),
    .addr    (addr_reg[IDX_W-1:0]),
    .wdata   (wdata_reg),
    .strb    (strb_reg),
    .rdata   (rd_word)
  );

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      state_reg   <= IDLE;
      wcnt_reg    <= '0;
      addr_reg    <= '0;
      write_reg   <= 1'b0;
      wdata_reg   <= '0;
      strb_reg    <= '0;
      proterr_reg <= 1'b0;
    end else begin
      proterr_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.p_sel && !bus.p_enable) begin
            state_reg <= ACCESS;
            wcnt_reg  <= WCNT_LOAD;
            addr_reg  <= bus.p_addr;
            write_reg <= bus.p_write;
            wdata_reg <= bus.p_wdata;
            strb_reg  <= bus.p_strb;
          end else if (bus.p_sel && bus.p_enable) begin
            proterr_reg <= 1'b1;
          end
        end
        ACCESS: begin
          if (!access_ok) begin
            state_reg   <= IDLE;
            wcnt_reg    <= '0;
            proterr_reg <= 1'b1;
          end else if (wcnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            wcnt_reg <= wcnt_reg - WCNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          wcnt_reg  <= '0;
        end
      endcase
    end
  end

  // Responses decode only from registered state, keeping inputs off the output paths.
  assign bus.p_ready   = ready;
  assign bus.p_slverr  = ready & err;
  assign bus.p_rdata   = (ready & ~write_reg & ~err) ? rd_word : '0;
  assign bus.p_proterr = proterr_reg;

endmodule
